seg7_multi_display: RTL and testbench
=====================================

# seg7_multi_display

Parametrised multi-digit 7-segment display controller for the DE2 HEX outputs. It accepts a binary value over a valid/ready handshake and renders it on NDIGITS active-low displays in either hexadecimal or unsigned decimal. Decimal rendering uses an iterative double-dabble converter. Optional leading-zero blanking, overflow indication and a blink mode are supported. It sits between CPU/IO-register logic and the HEX0..HEXn pins in `top`.

## Interface
- NDIGITS, 8, number of 7-segment digits driven (1..8)
- WIDTH, 32, input value width; must satisfy WIDTH <= 4*NDIGITS
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (>= 2)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  new value offered
- in_ready  out  1  controller can accept; transfer when in_valid && in_ready at a rising edge
- in_value  in  WIDTH  value to display
- in_mode  in  1  0 = hex, 1 = unsigned decimal; sampled with in_value
- in_blank_lz  in  1  blank leading zero digits; sampled with in_value
- blink_en  in  1  live (unsampled) blink enable
- busy  out  1  decimal conversion in progress (= ~in_ready)
- ovf  out  1  last committed decimal value exceeded NDIGITS digits
- segs  out  7*NDIGITS  digit i on bits [7i+6:7i]; bit0=a … bit6=g; active low

## Operation
- States: IDLE, CONV. Reset → IDLE.
- IDLE: in_ready=1.
  - Hex accept: commit nibbles of in_value, zero-extended to 4*NDIGITS, directly to the digit registers. Also latch blank_lz and clear ovf. Stay in IDLE.
  - Decimal accept: load the shift register with in_value, clear the BCD accumulator and the overflow flag, latch blank_lz, set iteration count = WIDTH, go to CONV.
- CONV: in_ready=0. Each cycle:
  - Add 3 to every BCD digit >= 5.
  - Shift {BCD, shift reg} left by 1.
  - A 1 shifted out of the top BCD digit sets the overflow flag.
  - Decrement the count. On the final iteration, commit BCD digits and ovf to the display registers and return to IDLE.
- in_valid during CONV is not accepted. The sender holds the value.
- Encoding of committed digit d (active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- ovf=1: every digit shows 7'h3F (dash), and blanking is ignored.
- Blanking (latched blank_lz=1): digits above the most significant nonzero digit show 7'h7F. Digit 0 is never blanked.
- Blink:
  - A free-running counter runs 0..BLINK_DIV-1. On wrap, the phase toggles.
  - When blink_en=1 and phase=off, all digits show 7'h7F.
  - The counter runs regardless of blink_en.
- segs is combinational from the committed registers, the blanking flag, ovf and the blink phase. No glitch requirement.

## Timing
- Reset values: state IDLE, in_ready=1, busy=0, ovf=0, committed digits all 0, blank flag 0, blink counter 0, phase on. Result: segs = 7'h40 on every digit.
- Hex latency: accept at edge k → new segs visible after edge k. Back-to-back hex accepts every cycle are legal.
- Decimal latency: accept at edge k → in_ready low for cycles k+1..k+WIDTH. Commit at edge k+WIDTH; in_ready=1 after it. The display holds the old value throughout CONV.
- Accepting a new value in the cycle in_ready returns high is legal.
- Blink: phase flips every BLINK_DIV cycles. Counter wrap BLINK_DIV-1 → 0.
- rst during CONV: abort, return to IDLE with reset display on the next cycle. No partial commit.
- rst takes priority over any simultaneous accept.
- blink_en change takes effect combinationally. It does not reset the counter.

## Test plan
- Reset (NDIGITS=8, WIDTH=32): assert rst 2 cycles → all digits 7'h40, in_ready=1, busy=0, ovf=0.
- Hex 32'h0000BEEF, blank_lz=0 → digits 0..3 = 0E, 06, 06, 03; digits 4..7 = 40.
  - Repeat with blank_lz=1 → digits 4..7 = 7F.
  - Value 0 with blank_lz=1 → digit0 = 40, others 7F.
- Decimal 12345, blank_lz=1 → in_ready low exactly 32 cycles.
  - Then digits 0..4 = 12, 19, 30, 24, 79; others 7F; ovf=0.
  - Display unchanged during CONV.
- Decimal 32'hFFFFFFFF → ovf=1 and all digits 3F after 32 cycles.
  - Then hex 32'h1 → ovf=0, digit0 = 79.
- Blink with BLINK_DIV=4, value 8 shown, blink_en=1 → digits alternate 4 cycles normal / 4 cycles 7F.
  - blink_en=0 mid-off-phase → display restored the same cycle.
- Reset mid-conversion: accept decimal 99, assert rst at cycle 10 of CONV → next cycle in_ready=1 and digits all 40.
  - in_valid held during CONV is accepted only after in_ready rises.

Source files
------------

// File: rtl/seg7_multi_display.sv
// seg7_multi_display
// Multi-digit active-low 7-segment controller. Values arrive over a
// valid/ready handshake and are rendered either as hex nibbles or, through
// an iterative double-dabble converter, as unsigned decimal. Supports
// leading-zero blanking, an overflow dash pattern and a free-running blink.

module seg7_multi_display #(
   parameter int NDIGITS   = 8,
   parameter int WIDTH     = 32,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_value,
   input  logic                   in_mode,
   input  logic                   in_blank_lz,
   input  logic                   blink_en,
   output logic                   busy,
   output logic                   ovf,
   output logic [7*NDIGITS-1:0]   segs
);

   localparam int DW   = 4 * NDIGITS;
   localparam int CNTW = $clog2(WIDTH + 1);
   localparam int CW   = $clog2(BLINK_DIV);

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  shreg;
   logic [DW-1:0]     bcd;
   logic              conv_ovf;
   logic [CNTW-1:0]   conv_cnt;
   logic              pend_blank;

   logic [DW-1:0]     disp_digits;
   logic              disp_ovf;
   logic              disp_blank;

   logic [CW-1:0]     blink_cnt;
   logic              blink_on;

   logic [DW-1:0]     hex_ext;
   logic [DW-1:0]     bcd_adj;
   logic [DW-1:0]     bcd_next;
   logic [WIDTH-1:0]  sh_next;
   logic              carry;

   logic [NDIGITS-1:0] lz_blank;
   logic               seen_nonzero;

   // Active-low segment pattern for one nibble (bit0=a .. bit6=g)
   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // One double-dabble step: add-3 correction then shift the joint register;
   // the bit leaving the top BCD digit means the result needs more digits
   always_comb begin
      hex_ext = '0;
      hex_ext[WIDTH-1:0] = in_value;
      bcd_adj = bcd;
      for (int i = 0; i < NDIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      {bcd_next, sh_next} = {bcd_adj, shreg} << 1;
      carry = bcd_adj[DW-1];
   end

   // Handshake/conversion FSM; display registers only change on a hex
   // accept or at the end of a conversion so the old value stays visible
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         shreg       <= '0;
         bcd         <= '0;
         conv_ovf    <= 1'b0;
         conv_cnt    <= '0;
         pend_blank  <= 1'b0;
         disp_digits <= '0;
         disp_ovf    <= 1'b0;
         disp_blank  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  if (!in_mode) begin
                     disp_digits <= hex_ext;
                     disp_blank  <= in_blank_lz;
                     disp_ovf    <= 1'b0;
                  end else begin
                     shreg      <= in_value;
                     bcd        <= '0;
                     conv_ovf   <= 1'b0;
                     pend_blank <= in_blank_lz;
                     conv_cnt   <= CNTW'(WIDTH);
                     in_ready   <= 1'b0;
                     state      <= CONV;
                  end
               end
            end
            CONV: begin
               shreg    <= sh_next;
               bcd      <= bcd_next;
               conv_ovf <= conv_ovf | carry;
               conv_cnt <= conv_cnt - CNTW'(1);
               if (conv_cnt == CNTW'(1)) begin
                  disp_digits <= bcd_next;
                  disp_ovf    <= conv_ovf | carry;
                  disp_blank  <= pend_blank;
                  in_ready    <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   // Free-running blink divider; phase toggles each time the counter wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + CW'(1);
      end
   end

   // Mark digits above the most significant nonzero digit; digit 0 always shows
   always_comb begin
      lz_blank     = '0;
      seen_nonzero = 1'b0;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         if (disp_digits[4*i +: 4] != 4'h0) begin
            seen_nonzero = 1'b1;
         end
         lz_blank[i] = disp_blank && !seen_nonzero && (i != 0);
      end
   end

   // Segment mux: blink-off beats overflow dashes, which beat blanking
   always_comb begin
      segs = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (blink_en && !blink_on) begin
            segs[7*i +: 7] = 7'h7F;
         end else if (disp_ovf) begin
            segs[7*i +: 7] = 7'h3F;
         end else if (lz_blank[i]) begin
            segs[7*i +: 7] = 7'h7F;
         end else begin
            segs[7*i +: 7] = hex7(disp_digits[4*i +: 4]);
         end
      end
   end

   // Status outputs derived from registered state
   always_comb begin
      busy = ~in_ready;
      ovf  = disp_ovf;
   end

endmodule

// File: tb/tb_seg7_multi_display.sv
// tb_seg7_multi_display
// Directed bench for seg7_multi_display with NDIGITS=8, WIDTH=32, BLINK_DIV=4.

module tb_seg7_multi_display;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        in_mode;
   logic        in_blank_lz;
   logic        blink_en;
   logic        busy;
   logic        ovf;
   logic [55:0] segs;

   int checks;
   int passes;

   typedef struct {
      logic [31:0] value;
      logic        mode;
      logic        blank;
      logic [55:0] exp_segs;
      logic        exp_ovf;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs[NVEC];

   logic [55:0] cur_exp;
   logic [1:0]  mcnt;
   logic        mphase;

   seg7_multi_display #(
      .NDIGITS(8),
      .WIDTH(32),
      .BLINK_DIV(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_value(in_value),
      .in_mode(in_mode),
      .in_blank_lz(in_blank_lz),
      .blink_en(blink_en),
      .busy(busy),
      .ovf(ovf),
      .segs(segs)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference blink phase: flips every 4 cycles after reset
   always @(posedge clk) begin
      if (rst) begin
         mcnt   <= 2'd0;
         mphase <= 1'b1;
      end else if (mcnt == 2'd3) begin
         mcnt   <= 2'd0;
         mphase <= ~mphase;
      end else begin
         mcnt <= mcnt + 2'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one table vector, wait through any conversion, then check result
   task automatic applyStimulus(input int idx);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      in_valid    = 1'b1;
      in_value    = vecs[idx].value;
      in_mode     = vecs[idx].mode;
      in_blank_lz = vecs[idx].blank;
      tick();
      in_valid = 1'b0;
      if (vecs[idx].mode) begin
         n = 0;
         while (!in_ready && n < 100) begin
            checkOutput($sformatf("vec%0d_hold", idx), 64'(segs), 64'(cur_exp));
            n++;
            tick();
         end
         checkOutput($sformatf("vec%0d_busy_cycles", idx), 64'(n), 64'd32);
      end
      checkOutput($sformatf("vec%0d_segs", idx), 64'(segs), 64'(vecs[idx].exp_segs));
      checkOutput($sformatf("vec%0d_ovf", idx), 64'(ovf), 64'(vecs[idx].exp_ovf));
      checkOutput($sformatf("vec%0d_ready", idx), 64'(in_ready), 64'd1);
      cur_exp = vecs[idx].exp_segs;
   endtask

   initial begin
      int n;
      int offs;
      logic [55:0] normal;

      checks = 0;
      passes = 0;

      vecs[0]  = '{32'h0000BEEF, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
      vecs[1]  = '{32'h0000BEEF, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
      vecs[2]  = '{32'h00000000, 1'b0, 1'b1, {{7{7'h7F}}, 7'h40}, 1'b0};
      vecs[3]  = '{32'h12345678, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0};
      vecs[4]  = '{32'hABCD0000, 1'b0, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
      vecs[5]  = '{32'd12345,    1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0};
      vecs[6]  = '{32'hFFFFFFFF, 1'b1, 1'b1, {8{7'h3F}}, 1'b1};
      vecs[7]  = '{32'h00000001, 1'b0, 1'b0, {{7{7'h40}}, 7'h79}, 1'b0};
      vecs[8]  = '{32'd99999999, 1'b1, 1'b1, {8{7'h10}}, 1'b0};
      vecs[9]  = '{32'd100000000, 1'b1, 1'b0, {8{7'h3F}}, 1'b1};
      vecs[10] = '{32'd1000,     1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40}, 1'b0};
      vecs[11] = '{32'd0,        1'b1, 1'b1, {{7{7'h7F}}, 7'h40}, 1'b0};

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_value    = '0;
      in_mode     = 1'b0;
      in_blank_lz = 1'b0;
      blink_en    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_segs", 64'(segs), 64'({8{7'h40}}));
      checkOutput("reset_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_ovf", 64'(ovf), 64'd0);
      cur_exp = {8{7'h40}};

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(i);
      end

      // Back-to-back hex accepts on consecutive edges
      in_valid    = 1'b1;
      in_mode     = 1'b0;
      in_blank_lz = 1'b0;
      in_value    = 32'h5;
      tick();
      checkOutput("b2b_first", 64'(segs), 64'({{7{7'h40}}, 7'h12}));
      in_value = 32'hC;
      tick();
      in_valid = 1'b0;
      checkOutput("b2b_second", 64'(segs), 64'({{7{7'h40}}, 7'h46}));

      // Valid held through a conversion is taken only once ready returns
      in_valid    = 1'b1;
      in_mode     = 1'b1;
      in_blank_lz = 1'b1;
      in_value    = 32'd12345;
      tick();
      in_mode     = 1'b0;
      in_blank_lz = 1'b0;
      in_value    = 32'h0000BEEF;
      n = 0;
      while (!in_ready && n < 100) begin
         checkOutput("held_hold", 64'(segs), 64'({{7{7'h40}}, 7'h46}));
         n++;
         tick();
      end
      checkOutput("held_busy_cycles", 64'(n), 64'd32);
      checkOutput("held_dec_result", 64'(segs), 64'(vecs[5].exp_segs));
      tick();
      in_valid = 1'b0;
      checkOutput("held_hex_result", 64'(segs), 64'(vecs[0].exp_segs));

      // Reset in the middle of a decimal conversion
      in_valid    = 1'b1;
      in_mode     = 1'b1;
      in_blank_lz = 1'b0;
      in_value    = 32'd99;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
      end
      checkOutput("midrst_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_ready", 64'(in_ready), 64'd1);
      checkOutput("midrst_segs", 64'(segs), 64'({8{7'h40}}));
      checkOutput("midrst_ovf", 64'(ovf), 64'd0);

      // Blink: value 8 shown, phase alternates every 4 cycles
      normal      = {{7{7'h40}}, 7'h00};
      in_valid    = 1'b1;
      in_mode     = 1'b0;
      in_blank_lz = 1'b0;
      in_value    = 32'h8;
      tick();
      in_valid = 1'b0;
      blink_en = 1'b1;
      #1;
      offs = 0;
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("blink_cyc%0d", i), 64'(segs), 64'(mphase ? normal : {8{7'h7F}}));
         if (segs == {8{7'h7F}}) offs++;
         tick();
      end
      checkOutput("blink_off_count", 64'(offs), 64'd8);
      n = 0;
      while (mphase && n < 20) begin
         tick();
         n++;
      end
      checkOutput("blink_off_before", 64'(segs), 64'({8{7'h7F}}));
      blink_en = 1'b0;
      #1;
      checkOutput("blink_restore", 64'(segs), 64'(normal));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
